// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register file.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_if.sv
// Write port, two read ports and the debug read port of the register file.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);

    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [ADDR_W-1:0] test_addr;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] test_data;

    modport master (
        output wen, waddr, wdata, raddr1, raddr2, test_addr,
        input  rdata1, rdata2, test_data
    );

    modport slave (
        input  wen, waddr, wdata, raddr1, raddr2, test_addr,
        output rdata1, rdata2, test_data
    );

endinterface

// File: rtl/regfile_read_port.sv
// Combinational read mux over the register array; index 0 always reads zero.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic [DATA_W-1:0] regs [1 << ADDR_W],
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = regs[addr];
        if (addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x DATA_W register file: one synchronous write port, three asynchronous read ports.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic      clk,
    input  logic      resetn,
    regfile_if.slave  bus
);

    localparam int NUM = 1 << ADDR_W;
    localparam int NUM_PORTS = 3;

    logic [DATA_W-1:0] regs_reg [NUM];
    logic [ADDR_W-1:0] port_addr [NUM_PORTS];
    logic [DATA_W-1:0] port_data [NUM_PORTS];

    // Reset wins over a concurrent write; writes to index 0 are dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (bus.wen && (bus.waddr != '0)) begin
            regs_reg[bus.waddr] <= bus.wdata;
        end
    end

    assign port_addr[0] = bus.raddr1;
    assign port_addr[1] = bus.raddr2;
    assign port_addr[2] = bus.test_addr;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_read
            regfile_read_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_read_port (
                .regs (regs_reg),
                .addr (port_addr[gi]),
                .data (port_data[gi])
            );
        end
    endgenerate

    assign bus.rdata1    = port_data[0];
    assign bus.rdata2    = port_data[1];
    assign bus.test_data = port_data[2];

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, write gating, x0, multi-port, read-during-write.
module tb_regfile;
    import regfile_pkg::*;

    logic clk;
    logic resetn;
    int   tests;
    int   fails;

    regfile_if bus ();

    regfile dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input reg_idx_t a, input reg_word_t d);
        bus.wen   = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        tick();
        bus.wen   = 1'b0;
        $display("[TB] write reg[%0d] <= 0x%08h", a, d);
    endtask

    task automatic test_reset();
        reg_idx_t a;
        resetn = 1'b0;
        bus.wen = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            a = reg_idx_t'(i);
            bus.raddr1    = a;
            bus.raddr2    = reg_idx_t'(NUM_REGS - 1 - i);
            bus.test_addr = a;
            #1;
            tests++;
            if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0 || bus.test_data !== 32'h0) begin
                fails++;
                $display("FAIL reset_sweep addr=%0d got r1=%h r2=%h t=%h want 0",
                         i, bus.rdata1, bus.rdata2, bus.test_data);
            end
        end
        $display("[TB] reset sweep done");
    endtask

    task automatic test_wen_gate();
        bus.waddr = 5'd3;
        bus.wdata = 32'h7D;
        bus.wen   = 1'b0;
        repeat (4) tick();
        bus.raddr1 = 5'd3;
        #1;
        tests++;
        if (bus.rdata1 !== 32'h0) begin
            fails++;
            $display("FAIL wen_low_hold got %h want 00000000", bus.rdata1);
        end
        write_reg(5'd3, 32'h7D);
        bus.raddr1 = 5'd3; bus.raddr2 = 5'd3; bus.test_addr = 5'd3;
        #1;
        tests++;
        if (bus.rdata1 !== 32'h7D) begin
            fails++;
            $display("FAIL wen_write_r1 got %h want 0000007d", bus.rdata1);
        end
        tests++;
        if (bus.rdata2 !== 32'h7D) begin
            fails++;
            $display("FAIL wen_write_r2 got %h want 0000007d", bus.rdata2);
        end
        tests++;
        if (bus.test_data !== 32'h7D) begin
            fails++;
            $display("FAIL wen_write_test got %h want 0000007d", bus.test_data);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(5'd0, 32'hFFFF_FFFF);
        bus.raddr1 = 5'd0; bus.raddr2 = 5'd0; bus.test_addr = 5'd0;
        #1;
        tests++;
        if (bus.rdata1 !== 32'h0 || bus.rdata2 !== 32'h0 || bus.test_data !== 32'h0) begin
            fails++;
            $display("FAIL zero_reg got r1=%h r2=%h t=%h want 0",
                     bus.rdata1, bus.rdata2, bus.test_data);
        end
    endtask

    task automatic test_multi_port();
        write_reg(5'd31, 32'hA5A5_A5A5);
        write_reg(5'd1, 32'h1234_5678);
        bus.raddr1 = 5'd31; bus.raddr2 = 5'd1; bus.test_addr = 5'd31;
        #1;
        tests++;
        if (bus.rdata1 !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL multi_r1 got %h want a5a5a5a5", bus.rdata1);
        end
        tests++;
        if (bus.rdata2 !== 32'h1234_5678) begin
            fails++;
            $display("FAIL multi_r2 got %h want 12345678", bus.rdata2);
        end
        tests++;
        if (bus.test_data !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL multi_test got %h want a5a5a5a5", bus.test_data);
        end
        // Address changes with no clock edge in between.
        bus.raddr1 = 5'd1; bus.raddr2 = 5'd3; bus.test_addr = 5'd2;
        #1;
        tests++;
        if (bus.rdata1 !== 32'h1234_5678 || bus.rdata2 !== 32'h7D || bus.test_data !== 32'h0) begin
            fails++;
            $display("FAIL async_read got r1=%h r2=%h t=%h want 12345678 0000007d 00000000",
                     bus.rdata1, bus.rdata2, bus.test_data);
        end
    endtask

    task automatic test_read_during_write();
        write_reg(5'd5, 32'h0000_1111);
        bus.raddr1 = 5'd5;
        bus.waddr  = 5'd5;
        bus.wdata  = 32'h0000_DEAD;
        bus.wen    = 1'b1;
        #1;
        tests++;
        if (bus.rdata1 !== 32'h0000_1111) begin
            fails++;
            $display("FAIL rdw_before got %h want 00001111", bus.rdata1);
        end
        tick();
        bus.wen = 1'b0;
        $display("[TB] write reg[5] <= 0x0000dead (read-during-write)");
        tests++;
        if (bus.rdata1 !== 32'h0000_DEAD) begin
            fails++;
            $display("FAIL rdw_after got %h want 0000dead", bus.rdata1);
        end
    endtask

    task automatic test_reset_priority();
        bus.waddr = 5'd7;
        bus.wdata = 32'h55;
        bus.wen   = 1'b1;
        resetn    = 1'b0;
        tick();
        resetn  = 1'b1;
        bus.wen = 1'b0;
        $display("[TB] reset with concurrent write reg[7] <= 0x00000055");
        bus.raddr1 = 5'd7; bus.raddr2 = 5'd31; bus.test_addr = 5'd5;
        #1;
        tests++;
        if (bus.rdata1 !== 32'h0) begin
            fails++;
            $display("FAIL reset_prio_r7 got %h want 00000000", bus.rdata1);
        end
        tests++;
        if (bus.rdata2 !== 32'h0 || bus.test_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_prio_clear got r2=%h t=%h want 0", bus.rdata2, bus.test_data);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetn = 1'b1;
        bus.wen = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr1 = '0;
        bus.raddr2 = '0;
        bus.test_addr = '0;
        tick();
        test_reset();
        test_wen_gate();
        test_zero_reg();
        test_multi_port();
        test_read_during_write();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
